// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
//   UART_DATA_W  : payload width of one received character
//   UART_ENTRY_W : stored entry width, {err, data}
//   rx_entry_t   : one FIFO entry as captured from the receiver
package uart_pkg;

   localparam int unsigned UART_DATA_W  = 8;
   localparam int unsigned UART_ENTRY_W = UART_DATA_W + 1;

   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver-side write signals, host-side read signals and status for uart_rx_fifo.
//   master : bench/host view, drives wr_*, rd_en, handshake, clr_status; observes status
//   slave  : FIFO view, the reverse
interface uart_rx_fifo_if #(
   parameter int unsigned ADDR_W = 4
);
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] wr_data;
   logic                   wr_error;
   logic                   wr_ready;
   logic                   handshake;
   logic                   rd_en;
   logic                   clr_status;
   logic [UART_DATA_W-1:0] rd_data;
   logic                   rd_error;
   logic                   empty;
   logic                   full;
   logic [ADDR_W:0]        count;
   logic                   rts;
   logic                   overrun;
   logic [7:0]             err_count;

   modport master (
      output wr_data, wr_error, wr_ready, handshake, rd_en, clr_status,
      input  rd_data, rd_error, empty, full, count, rts, overrun, err_count
   );

   modport slave (
      input  wr_data, wr_error, wr_ready, handshake, rd_en, clr_status,
      output rd_data, rd_error, empty, full, count, rts, overrun, err_count
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x entry storage: synchronous write, asynchronous read, array is not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to store
//   raddr_i : read address
//   rdata_o : entry at raddr_i, combinational
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  rx_entry_t         wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output rx_entry_t         rdata_o
);

   rx_entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO with rts hysteresis,
// sticky overrun flag and saturating frame-error count.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_rx_fifo_if slave (wr_* from receiver, rd_en/status to host)
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned RTS_HI = 12,
   parameter int unsigned RTS_LO = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_rx_fifo_if.slave bus
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic              ready_q;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rts_q, rts_d;
   logic              overrun_q, overrun_d;
   logic [7:0]        err_count_q, err_count_d;

   logic      push, pop, wr_en, drop, empty, full;
   rx_entry_t wr_entry, head_entry;

   assign wr_entry = '{err: bus.wr_error, data: bus.wr_data};

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (wptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rptr_q),
      .rdata_o (head_entry)
   );

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CNT_W'(DEPTH));
      // Rising edge of wr_ready only, so a held level yields one push.
      push  = bus.wr_ready & ~ready_q;
      pop   = bus.rd_en & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;

      wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;

      count_d = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !wr_en) begin
         count_d = count_q - 1'b1;
      end

      // Set events take priority over clr_status.
      overrun_d = overrun_q;
      if (bus.clr_status) overrun_d = 1'b0;
      if (drop)           overrun_d = 1'b1;

      err_count_d = err_count_q;
      if (bus.clr_status) err_count_d = '0;
      if (wr_en && bus.wr_error) begin
         if (bus.clr_status)              err_count_d = 8'd1;
         else if (err_count_q != 8'hFF)   err_count_d = err_count_q + 8'd1;
      end

      // Hysteresis on the next count; between thresholds rts holds.
      rts_d = rts_q;
      if (!bus.handshake) begin
         rts_d = 1'b1;
      end else if (count_d >= CNT_W'(RTS_HI)) begin
         rts_d = 1'b0;
      end else if (count_d <= CNT_W'(RTS_LO)) begin
         rts_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rts_q       <= 1'b1;
         overrun_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         ready_q     <= bus.wr_ready;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rts_q       <= rts_d;
         overrun_q   <= overrun_d;
         err_count_q <= err_count_d;
      end
   end

   // Head is forced to zero while empty so stale array contents never leak out.
   assign bus.rd_data   = empty ? '0 : head_entry.data;
   assign bus.rd_error  = empty ? 1'b0 : head_entry.err;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.rts       = rts_q;
   assign bus.overrun   = overrun_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scoreboard queue of expected {err,data} entries,
// one task per scenario.
module tb_uart_rx_fifo;

   logic clk;
   logic rst_n;

   uart_rx_fifo_if #(.ADDR_W(4)) bus ();

   uart_rx_fifo #(
      .DEPTH  (16),
      .ADDR_W (4),
      .RTS_HI (12),
      .RTS_LO (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fail;
   int          exp_err;
   logic [8:0]  sb [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle wr_ready pulse, then one low cycle so the next pulse is a fresh edge.
   task automatic push_frame(input logic [7:0] d, input logic e);
      bus.wr_data  = d;
      bus.wr_error = e;
      bus.wr_ready = 1'b1;
      tick();
      bus.wr_ready = 1'b0;
      tick();
      if (sb.size() < 16) begin
         sb.push_back({e, d});
         if (e && exp_err < 255) exp_err++;
      end
   endtask

   task automatic pop_check(input string name);
      logic [8:0] exp;
      if (sb.size() == 0) begin
         $display("FAIL %s: scoreboard empty, nothing expected", name);
         n_fail++;
         n_checks++;
         return;
      end
      exp = sb.pop_front();
      if ({bus.rd_error, bus.rd_data} !== exp) begin
         $display("FAIL %s: head got %h expected %h", name, {bus.rd_error, bus.rd_data}, exp);
         n_fail++;
      end
      n_checks++;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      if ({bus.empty, bus.full, bus.count, bus.rts, bus.overrun} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
         $display("FAIL reset_flags: got e=%b f=%b c=%0d rts=%b ovr=%b expected 1 0 0 1 0",
                  bus.empty, bus.full, bus.count, bus.rts, bus.overrun);
         n_fail++;
      end
      n_checks++;
      if ({bus.err_count, bus.rd_error, bus.rd_data} !== 17'd0) begin
         $display("FAIL reset_data: got errc=%0d rerr=%b rd=%h expected 0 0 00",
                  bus.err_count, bus.rd_error, bus.rd_data);
         n_fail++;
      end
      n_checks++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      push_frame(8'hA5, 1'b0);
      if ({bus.empty, bus.count, bus.rd_data} !== {1'b0, 5'd1, 8'hA5}) begin
         $display("FAIL single_push: got e=%b c=%0d rd=%h expected 0 1 a5",
                  bus.empty, bus.count, bus.rd_data);
         n_fail++;
      end
      n_checks++;
      pop_check("single_pop");
      if (bus.empty !== 1'b1) begin
         $display("FAIL single_empty: got %b expected 1", bus.empty);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_level();
      bus.wr_data  = 8'h3C;
      bus.wr_error = 1'b0;
      bus.wr_ready = 1'b1;
      repeat (5) tick();
      bus.wr_ready = 1'b0;
      tick();
      sb.push_back(9'h03C);
      if (bus.count !== 5'd1) begin
         $display("FAIL level_once: count got %0d expected 1", bus.count);
         n_fail++;
      end
      n_checks++;
      push_frame(8'h3C, 1'b0);
      if (bus.count !== 5'd2) begin
         $display("FAIL level_again: count got %0d expected 2", bus.count);
         n_fail++;
      end
      n_checks++;
      pop_check("level_pop0");
      pop_check("level_pop1");
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) push_frame(8'(i), 1'b0);
      if ({bus.full, bus.overrun} !== 2'b10) begin
         $display("FAIL ovr_fill: got full=%b ovr=%b expected 1 0", bus.full, bus.overrun);
         n_fail++;
      end
      n_checks++;
      push_frame(8'hFF, 1'b0);
      if ({bus.full, bus.overrun, bus.count} !== {1'b1, 1'b1, 5'd16}) begin
         $display("FAIL ovr_drop: got full=%b ovr=%b c=%0d expected 1 1 16",
                  bus.full, bus.overrun, bus.count);
         n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 16; i++) pop_check("ovr_drain");
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      if ({bus.overrun, bus.empty} !== 2'b01) begin
         $display("FAIL ovr_clear: got ovr=%b e=%b expected 0 1", bus.overrun, bus.empty);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_rts();
      bus.handshake = 1'b1;
      for (int i = 0; i < 11; i++) push_frame(8'h40 + 8'(i), 1'b0);
      if (bus.rts !== 1'b1) begin
         $display("FAIL rts_at11: got %b expected 1", bus.rts);
         n_fail++;
      end
      n_checks++;
      push_frame(8'h4B, 1'b0);
      if (bus.rts !== 1'b0) begin
         $display("FAIL rts_at12: got %b expected 0", bus.rts);
         n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 7; i++) pop_check("rts_pop");
      if ({bus.count, bus.rts} !== {5'd5, 1'b0}) begin
         $display("FAIL rts_hold5: got c=%0d rts=%b expected 5 0", bus.count, bus.rts);
         n_fail++;
      end
      n_checks++;
      pop_check("rts_pop");
      if ({bus.count, bus.rts} !== {5'd4, 1'b1}) begin
         $display("FAIL rts_lo4: got c=%0d rts=%b expected 4 1", bus.count, bus.rts);
         n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 8; i++) push_frame(8'h60 + 8'(i), 1'b0);
      if (bus.rts !== 1'b0) begin
         $display("FAIL rts_refill: got %b expected 0", bus.rts);
         n_fail++;
      end
      n_checks++;
      bus.handshake = 1'b0;
      tick();
      if (bus.rts !== 1'b1) begin
         $display("FAIL rts_hs_off: got %b expected 1", bus.rts);
         n_fail++;
      end
      n_checks++;
      while (sb.size() > 0) pop_check("rts_drain");
   endtask

   task automatic test_simul();
      for (int i = 0; i < 16; i++) push_frame(8'h80 + 8'(i), 1'b0);
      bus.wr_data  = 8'hEE;
      bus.wr_error = 1'b0;
      bus.wr_ready = 1'b1;
      bus.rd_en    = 1'b1;
      tick();
      bus.wr_ready = 1'b0;
      bus.rd_en    = 1'b0;
      void'(sb.pop_front());
      sb.push_back(9'h0EE);
      if ({bus.count, bus.full, bus.overrun} !== {5'd16, 1'b1, 1'b0}) begin
         $display("FAIL simul_full: got c=%0d f=%b ovr=%b expected 16 1 0",
                  bus.count, bus.full, bus.overrun);
         n_fail++;
      end
      n_checks++;
      tick();
      while (sb.size() > 0) pop_check("simul_drain");
   endtask

   task automatic test_err_and_reset();
      push_frame(8'h11, 1'b1);
      push_frame(8'h22, 1'b1);
      push_frame(8'h33, 1'b1);
      push_frame(8'h44, 1'b0);
      if (bus.err_count !== 8'(exp_err)) begin
         $display("FAIL err_count3: got %0d expected %0d", bus.err_count, exp_err);
         n_fail++;
      end
      n_checks++;
      pop_check("err_head");
      // clr_status coinciding with an error push leaves the count at 1.
      bus.wr_data    = 8'h55;
      bus.wr_error   = 1'b1;
      bus.wr_ready   = 1'b1;
      bus.clr_status = 1'b1;
      tick();
      bus.wr_ready   = 1'b0;
      bus.clr_status = 1'b0;
      tick();
      sb.push_back(9'h155);
      exp_err = 1;
      if (bus.err_count !== 8'(exp_err)) begin
         $display("FAIL err_clr_win: got %0d expected %0d", bus.err_count, exp_err);
         n_fail++;
      end
      n_checks++;
      pop_check("err_head2");
      // Asynchronous reset mid-stream, checked before any clock edge.
      bus.wr_data  = 8'h77;
      bus.wr_ready = 1'b1;
      rst_n        = 1'b0;
      #2;
      if ({bus.empty, bus.full, bus.count, bus.rts, bus.overrun, bus.err_count,
           bus.rd_error, bus.rd_data} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
         $display("FAIL mid_reset: got e=%b f=%b c=%0d rts=%b ovr=%b errc=%0d rerr=%b rd=%h",
                  bus.empty, bus.full, bus.count, bus.rts, bus.overrun, bus.err_count,
                  bus.rd_error, bus.rd_data);
         n_fail++;
      end
      n_checks++;
      sb.delete();
      exp_err = 0;
      bus.wr_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      push_frame(8'h9A, 1'b0);
      if ({bus.count, bus.rd_data} !== {5'd1, 8'h9A}) begin
         $display("FAIL post_reset: got c=%0d rd=%h expected 1 9a", bus.count, bus.rd_data);
         n_fail++;
      end
      n_checks++;
      pop_check("post_reset_pop");
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      exp_err        = 0;
      rst_n          = 1'b1;
      bus.wr_data    = '0;
      bus.wr_error   = 1'b0;
      bus.wr_ready   = 1'b0;
      bus.handshake  = 1'b0;
      bus.rd_en      = 1'b0;
      bus.clr_status = 1'b0;
      #3;
      test_reset();
      test_single();
      test_level();
      test_overrun();
      test_rts();
      test_simul();
      test_err_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
